// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and helpers for the 7-segment scan driver
//
// Purpose : segment patterns {g,f,e,d,c,b,a} (active-low form), converter
//           state encoding and constant helper functions used for sizing.
// Ports   : none (package).
package seg7_pkg;

  localparam logic [6:0] SEG7_DIGIT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;
  localparam logic [6:0] SEG7_MINUS = 7'b0111111;

  localparam logic [1:0] CONV_IDLE  = 2'd0;
  localparam logic [1:0] CONV_SHIFT = 2'd1;
  localparam logic [1:0] CONV_DONE  = 2'd2;

  // Bits needed to hold 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  // Non-decimal nibbles cannot occur from the converter; blank them anyway.
  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    if (d > 4'd9) return SEG7_BLANK;
    return SEG7_DIGIT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
//
// Purpose : accepts a binary value on a valid/ready handshake, converts it in
//           VALUE_W shift cycles and publishes bcd/ovf together one cycle later.
// Ports   : clk, reset_n (async active-low)
//           value_in/value_valid/value_ready : input handshake
//           bcd : NUM_DIGITS packed nibbles, digit 0 in bits [3:0]
//           ovf : last value did not fit in NUM_DIGITS decimal digits
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int VALUE_W    = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [VALUE_W-1:0]      value_in,
  input  logic                    value_valid,
  output logic                    value_ready,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = clog2(VALUE_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VALUE_W - 1);
  localparam longint unsigned OVF_LIMIT = pow10(NUM_DIGITS);

  logic [1:0]         r_state;
  logic [VALUE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_next;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_ready;
  logic [BCD_W-1:0]   w_adj;
  logic               w_ovf_cap;

  assign w_ovf_cap   = (64'(value_in) >= OVF_LIMIT);
  assign value_ready = r_ready;
  assign bcd         = r_bcd;
  assign ovf         = r_ovf;

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= CONV_IDLE;
      r_bin      <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_next <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      case (r_state)
        CONV_IDLE: begin
          if (value_valid) begin
            r_bin      <= value_in;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_next <= w_ovf_cap;
            r_ready    <= 1'b0;
            r_state    <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          // Truncating cast drops the top bit of the topmost nibble; it only
          // matters when the value overflows, and ovf masks the display then.
          r_scratch <= BCD_W'({w_adj, r_bin[VALUE_W-1]});
          r_bin     <= r_bin << 1;
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= CONV_DONE;
        end
        CONV_DONE: begin
          r_bcd   <= r_scratch;
          r_ovf   <= r_ovf_next;
          r_ready <= 1'b1;
          r_state <= CONV_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= CONV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed driver for NUM_DIGITS 7-segment digits
//
// Purpose : converts a binary value to BCD and scans the digits round-robin on
//           a shared segment bus with leading-zero blanking and overflow dash.
//           Optional blinking is compiled in with `define SEG7_BLINK_EN.
// Ports   : clk, reset_n (async active-low)
//           value_in/value_valid/value_ready : value handshake
//           lz_blank   : blank leading zeros
//           blink_mask : per-digit blink enable (SEG7_BLINK_EN only)
//           seg_out    : segments {g,f,e,d,c,b,a}
//           digit_en   : one-hot digit enable, active-high
//           ovf        : last value exceeded 10**NUM_DIGITS-1
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int VALUE_W        = 8,
  parameter int NUM_DIGITS     = 3,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_DIV      = 25
`endif
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    value_in,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic                  lz_blank,
`ifdef SEG7_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  ovf
);

  localparam int PRE_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_RESET = (SEG_ACTIVE_LOW != 0) ? SEG7_DIGIT[0] : ~SEG7_DIGIT[0];

  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic                    w_ovf;
  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_adv;
  logic                    w_tc;
  logic                    w_wrap;
  logic                    w_blink_hit;
  logic [4*NUM_DIGITS-1:0] w_upper;
  logic [6:0]              w_pat;
  logic [6:0]              w_seg_next;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk         (clk),
    .reset_n     (reset_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .bcd         (w_bcd),
    .ovf         (w_ovf)
  );

  assign ovf       = w_ovf;
  assign w_tc      = (r_pre == PRE_LAST);
  assign w_wrap    = w_tc && (r_idx == IDX_LAST);
  assign w_idx_adv = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

`ifdef SEG7_BLINK_EN
  localparam int BLK_W = clog2(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] r_blink_cnt;
  logic             r_phase;
  logic             w_phase_next;

  // The digit loaded on the wrap edge must already see the new phase.
  assign w_phase_next = (w_wrap && r_blink_cnt == BLK_LAST) ? ~r_phase : r_phase;
  assign w_blink_hit  = w_phase_next & blink_mask[w_idx_adv];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_wrap) begin
      r_blink_cnt <= (r_blink_cnt == BLK_LAST) ? '0 : r_blink_cnt + 1'b1;
      r_phase     <= w_phase_next;
    end
  end
`else
  assign w_blink_hit = 1'b0;
`endif

  // Pattern for the digit about to be enabled. w_upper holds that digit and
  // every more-significant one, so a zero value means it is a leading zero.
  always_comb begin
    w_upper = w_bcd >> (4 * w_idx_adv);
    w_pat   = seg7_decode(w_upper[3:0]);
    if (w_ovf) begin
      w_pat = SEG7_MINUS;
    end else if (lz_blank && (w_idx_adv != '0) && (w_upper == '0)) begin
      w_pat = SEG7_BLANK;
    end
    if (w_blink_hit) w_pat = SEG7_BLANK;
    w_seg_next = (SEG_ACTIVE_LOW != 0) ? w_pat : ~w_pat;
  end

  // seg_out and digit_en load only on a digit advance and from the same
  // index, so they switch together and a new value waits for the next digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre    <= '0;
      r_idx    <= '0;
      digit_en <= NUM_DIGITS'(1);
      seg_out  <= SEG_RESET;
    end else begin
      r_pre <= w_tc ? '0 : r_pre + 1'b1;
      if (w_tc) begin
        r_idx    <= w_idx_adv;
        digit_en <= NUM_DIGITS'(1) << w_idx_adv;
        seg_out  <= w_seg_next;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [2:0] en;
    logic [6:0] seg;
  } exp_t;

  localparam logic [6:0] TBL [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lz_blank = 1'b0;
  logic [7:0] value8 = '0;
  logic       valid8 = 1'b0;
  logic       ready8;
  logic [6:0] seg8;
  logic [2:0] en8;
  logic       ovf8;
  logic [9:0] value10 = '0;
  logic       valid10 = 1'b0;
  logic       ready10;
  logic [6:0] seg10;
  logic [2:0] en10;
  logic       ovf10;
  logic [2:0] blink_mask = '0;

  logic       sel = 1'b0;
  logic       obs_ready;
  logic [6:0] obs_seg;
  logic [2:0] obs_en;

  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign obs_ready = sel ? ready10 : ready8;
  assign obs_seg   = sel ? seg10 : seg8;
  assign obs_en    = sel ? en10 : en8;

  seg7_scan_driver #(
    .VALUE_W (8), .NUM_DIGITS (3), .SCAN_DIV (4), .SEG_ACTIVE_LOW (1)
`ifdef SEG7_BLINK_EN
    , .BLINK_DIV (2)
`endif
  ) u_dut (
    .clk (clk), .reset_n (reset_n), .value_in (value8), .value_valid (valid8),
    .value_ready (ready8), .lz_blank (lz_blank),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg_out (seg8), .digit_en (en8), .ovf (ovf8)
  );

  seg7_scan_driver #(
    .VALUE_W (10), .NUM_DIGITS (3), .SCAN_DIV (4), .SEG_ACTIVE_LOW (1)
  ) u_dut10 (
    .clk (clk), .reset_n (reset_n), .value_in (value10), .value_valid (valid10),
    .value_ready (ready10), .lz_blank (lz_blank),
`ifdef SEG7_BLINK_EN
    .blink_mask (3'b000),
`endif
    .seg_out (seg10), .digit_en (en10), .ovf (ovf10)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] model_seg(input int v, input bit lz, input int i);
    int up;
    up = v / (10 ** i);
    if (v >= 1000) return 7'b0111111;
    if (lz && i != 0 && up == 0) return 7'b1111111;
    return TBL[up % 10];
  endfunction

  task automatic expect_round(input int v, input bit lz);
    for (int i = 0; i < 3; i++) sb.push_back('{en: 3'(1 << i), seg: model_seg(v, lz, i)});
  endtask

  task automatic load_accept(input int v);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (obs_ready) break;
    end
    if (sel) begin value10 = 10'(v); valid10 = 1'b1; end
    else     begin value8  = 8'(v);  valid8  = 1'b1; end
    @(posedge clk);
    #1;
    valid8  = 1'b0;
    valid10 = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (obs_ready) break;
      n++;
    end
  endtask

  // Captures one full scan round starting at the next advance onto digit 0.
  task automatic observe_raw(output logic [20:0] segs, output logic [8:0] ens, output bit ok);
    logic [2:0] prev;
    bit found;
    prev = obs_en;
    ok   = 1'b1;
    segs = '0;
    ens  = '0;
    for (int k = 0; k < 3; k++) begin
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (obs_en !== prev) begin
          prev = obs_en;
          if (k != 0 || obs_en == 3'b001) begin
            found = 1'b1;
            break;
          end
        end
      end
      if (!found) ok = 1'b0;
      segs[7*k +: 7] = obs_seg;
      ens[3*k +: 3]  = obs_en;
    end
  endtask

  task automatic observe_round(input string tag);
    logic [20:0] segs;
    logic [8:0]  ens;
    bit          ok;
    exp_t        e;
    observe_raw(segs, ens, ok);
    check_val({tag, "_scan"}, 32'(ok), 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (sb.size() == 0) break;
      e = sb.pop_front();
      check_val($sformatf("%s_d%0d_en", tag, k), 32'(ens[3*k +: 3]), 32'(e.en));
      check_val($sformatf("%s_d%0d_seg", tag, k), 32'(segs[7*k +: 7]), 32'(e.seg));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rst_seg", 32'(seg8), 32'h40);
    check_val("rst_en", 32'(en8), 32'h1);
    check_val("rst_ready", 32'(ready8), 32'h1);
    check_val("rst_ovf", 32'(ovf8), 32'h0);

    expect_round(255, 1'b0);
    load_accept(255);
    wait_ready(n);
    check_val("busy255", 32'(n), 32'd9);
    check_val("ovf255", 32'(ovf8), 32'd0);
    observe_round("v255");

    lz_blank = 1'b1;
    expect_round(7, 1'b1);
    load_accept(7);
    wait_ready(n);
    check_val("busy7", 32'(n), 32'd9);
    observe_round("v7_lz");
    lz_blank = 1'b0;
    expect_round(7, 1'b0);
    observe_round("v7_nolz");

    // A second offer while busy must be ignored.
    expect_round(42, 1'b0);
    load_accept(42);
    value8 = 8'd99;
    valid8 = 1'b1;
    repeat (5) @(negedge clk);
    valid8 = 1'b0;
    wait_ready(n);
    observe_round("v42_busy");

    sel = 1'b1;
    expect_round(1000, 1'b0);
    load_accept(1000);
    wait_ready(n);
    check_val("busy1000", 32'(n), 32'd11);
    check_val("ovf1000", 32'(ovf10), 32'd1);
    observe_round("v1000");
    expect_round(999, 1'b0);
    load_accept(999);
    wait_ready(n);
    check_val("ovf999", 32'(ovf10), 32'd0);
    observe_round("v999");

    sel = 1'b0;
    load_accept(123);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_seg", 32'(seg8), 32'h40);
    check_val("mid_rst_en", 32'(en8), 32'h1);
    check_val("mid_rst_ready", 32'(ready8), 32'h1);
    check_val("mid_rst_ovf", 32'(ovf8), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    expect_round(0, 1'b0);
    observe_round("after_rst");
    check_val("after_rst_ready", 32'(ready8), 32'h1);

`ifdef SEG7_BLINK_EN
    begin
      logic [20:0] segs;
      logic [8:0]  ens;
      bit          ok;
      bit          b[8];
      int          changes;
      blink_mask = 3'b100;
      load_accept(42);
      wait_ready(n);
      changes = 0;
      for (int r = 0; r < 8; r++) begin
        observe_raw(segs, ens, ok);
        check_val("blink_scan", 32'(ok), 32'd1);
        check_val("blink_d0", 32'(segs[6:0]), 32'(TBL[2]));
        check_val("blink_d1", 32'(segs[13:7]), 32'(TBL[4]));
        b[r] = (segs[20:14] == 7'b1111111);
        check_val("blink_d2_legal", 32'(b[r] || segs[20:14] == TBL[0]), 32'd1);
        if (r >= 1 && b[r] != b[r-1]) changes++;
        if (r >= 2 && b[r] != b[r-1]) check_val("blink_period", 32'(b[r-1] == b[r-2]), 32'd1);
      end
      check_val("blink_changes", 32'(changes >= 3), 32'd1);
      blink_mask = 3'b000;
    end
`endif

    check_val("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
